// File: rtl/connect4_pkg.sv
// Shared definitions for the Connect-4 win checker: board geometry,
// cell encoding, checker state enum and a bounds-safe cell accessor.
package connect4_pkg;

   localparam int ROWS    = 6;
   localparam int COLS    = 7;
   localparam int CELLS   = ROWS * COLS;
   localparam int BOARD_W = 2 * CELLS;
   localparam int IDX_W   = 6;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P1    = 2'b01,
      P2    = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } chk_state_t;

   // Returns the cell at (r,c); off-board positions and the unused 11 code
   // both read as EMPTY so callers never have to special-case them.
   function automatic cell_t cell_at(input logic [BOARD_W-1:0] b,
                                     input int r,
                                     input int c);
      logic [1:0] raw;
      if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
         return EMPTY;
      end
      raw = b[2*(r*COLS+c) +: 2];
      case (raw)
         2'b01:   return P1;
         2'b10:   return P2;
         default: return EMPTY;
      endcase
   endfunction

endpackage

// File: rtl/connect4_win_checker_line4_eval.sv
// Combinational evaluation of one anchor cell: tests the horizontal,
// vertical, up-right and up-left lines of four starting at (row,col).
import connect4_pkg::*;

module line4_eval (
   input  logic [BOARD_W-1:0] snap,
   input  logic [2:0]         row,
   input  logic [2:0]         col,
   output logic               hit,
   output cell_t              player
);

   cell_t      anchor;
   logic [3:0] line_hit;

   assign anchor = cell_at(snap, int'(row), int'(col));

   // Direction gi: 0 horizontal, 1 vertical, 2 up-right, 3 up-left.
   for (genvar gi = 0; gi < 4; gi++) begin : g_dir
      localparam int DR = (gi == 0) ? 0 : 1;
      localparam int DC = (gi == 1) ? 0 : ((gi == 3) ? -1 : 1);

      logic in_range;

      // A line only counts if its far end is still on the board.
      assign in_range = (int'(row) + 3*DR < ROWS) &&
                        (int'(col) + 3*DC >= 0)   &&
                        (int'(col) + 3*DC < COLS);

      assign line_hit[gi] = in_range && (anchor != EMPTY) &&
         (cell_at(snap, int'(row) + 1*DR, int'(col) + 1*DC) == anchor) &&
         (cell_at(snap, int'(row) + 2*DR, int'(col) + 2*DC) == anchor) &&
         (cell_at(snap, int'(row) + 3*DR, int'(col) + 3*DC) == anchor);
   end

   assign hit    = |line_hit;
   assign player = hit ? anchor : EMPTY;

endmodule

// File: rtl/connect4_win_checker.sv
// Sequential Connect-4 win checker: snapshots the board on request and
// walks the 42 anchor cells one per cycle, stopping at the first line.
import connect4_pkg::*;

module connect4_win_checker (
   input  logic               clk,
   input  logic               rst,
   input  logic               check_win,
   input  logic [BOARD_W-1:0] board,
   output logic               busy,
   output logic               done,
   output logic               win_flag,
   output logic [1:0]         winner_id,
   output logic               board_full
);

   chk_state_t         state_reg;
   logic [BOARD_W-1:0] snap_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic [2:0]         row_reg;
   logic [2:0]         col_reg;

   // One-cycle pipeline between anchor evaluation and the stop decision.
   logic               eval_valid_reg;
   logic               eval_hit_reg;
   cell_t              eval_player_reg;
   logic               eval_last_reg;

   logic               busy_reg;
   logic               done_reg;
   logic               win_flag_reg;
   cell_t              winner_id_reg;
   logic               board_full_reg;

   logic               line_hit;
   cell_t              line_player;
   logic [CELLS-1:0]   cell_filled;
   logic               snap_full;

   line4_eval u_line4_eval (
      .snap   (snap_reg),
      .row    (row_reg),
      .col    (col_reg),
      .hit    (line_hit),
      .player (line_player)
   );

   // Per-cell occupancy of the snapshot; 11 counts as empty.
   for (genvar gi = 0; gi < CELLS; gi++) begin : g_full
      assign cell_filled[gi] = (snap_reg[2*gi +: 2] == 2'b01) ||
                               (snap_reg[2*gi +: 2] == 2'b10);
   end

   assign snap_full = &cell_filled;

   // Checker FSM: accept request, scan anchors, report for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         idx_reg         <= '0;
         row_reg         <= '0;
         col_reg         <= '0;
         eval_valid_reg  <= 1'b0;
         eval_hit_reg    <= 1'b0;
         eval_player_reg <= EMPTY;
         eval_last_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         win_flag_reg    <= 1'b0;
         winner_id_reg   <= EMPTY;
         board_full_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               done_reg <= 1'b0;
               if (check_win) begin
                  snap_reg       <= board;
                  idx_reg        <= '0;
                  row_reg        <= '0;
                  col_reg        <= '0;
                  eval_valid_reg <= 1'b0;
                  eval_hit_reg   <= 1'b0;
                  eval_last_reg  <= 1'b0;
                  win_flag_reg   <= 1'b0;
                  winner_id_reg  <= EMPTY;
                  board_full_reg <= 1'b0;
                  busy_reg       <= 1'b1;
                  state_reg      <= ST_SCAN;
               end
            end

            ST_SCAN: begin
               if (eval_valid_reg && (eval_hit_reg || eval_last_reg)) begin
                  win_flag_reg   <= eval_hit_reg;
                  winner_id_reg  <= eval_hit_reg ? eval_player_reg : EMPTY;
                  board_full_reg <= snap_full;
                  done_reg       <= 1'b1;
                  state_reg      <= ST_DONE;
               end else begin
                  eval_valid_reg  <= 1'b1;
                  eval_hit_reg    <= line_hit;
                  eval_player_reg <= line_player;
                  eval_last_reg   <= (idx_reg == IDX_W'(CELLS - 1));
                  idx_reg         <= idx_reg + 6'd1;
                  if (col_reg == 3'(COLS - 1)) begin
                     col_reg <= '0;
                     row_reg <= row_reg + 3'd1;
                  end else begin
                     col_reg <= col_reg + 3'd1;
                  end
               end
            end

            ST_DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end

            default: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign win_flag   = win_flag_reg;
   assign winner_id  = winner_id_reg;
   assign board_full = board_full_reg;

endmodule

// File: tb/tb_connect4_win_checker.sv
// Scoreboard bench for connect4_win_checker: each accepted scan pushes its
// expected latency and result; the done monitor pops and compares.
module tb_connect4_win_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        check_win = 1'b0;
   logic [83:0] board = '0;
   logic        busy, done, win_flag, board_full;
   logic [1:0]  winner_id;

   typedef struct {
      string      tag;
      int         start;
      int         lat;
      logic       win;
      logic [1:0] who;
      logic       full;
   } exp_t;

   exp_t sb[$];
   int   cyc_cnt = 0;
   int   n_vec = 0;
   int   n_err = 0;

   connect4_win_checker dut (
      .clk        (clk),
      .rst        (rst),
      .check_win  (check_win),
      .board      (board),
      .busy       (busy),
      .done       (done),
      .win_flag   (win_flag),
      .winner_id  (winner_id),
      .board_full (board_full)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] cell_v(input logic [83:0] b, input int r, input int c);
      logic [1:0] v;
      v = b[2*(r*7+c) +: 2];
      return (v == 2'b11) ? 2'b00 : v;
   endfunction

   function automatic logic [83:0] put(input logic [83:0] b, input int r, input int c,
                                       input logic [1:0] v);
      logic [83:0] t;
      t = b;
      t[2*(r*7+c) +: 2] = v;
      return t;
   endfunction

   // Reference: first anchor in scan order with any line of four.
   function automatic void ref_eval(input logic [83:0] b, output int anchor,
                                    output logic [1:0] who, output logic full);
      int drs [4] = '{0, 1, 1, 1};
      int dcs [4] = '{1, 0, 1, -1};
      anchor = -1;
      who    = 2'b00;
      full   = 1'b1;
      for (int k = 0; k < 42; k++)
         if (cell_v(b, k / 7, k % 7) == 2'b00) full = 1'b0;
      for (int k = 0; k < 42 && anchor < 0; k++) begin
         int r = k / 7;
         int c = k % 7;
         logic [1:0] a = cell_v(b, r, c);
         if (a != 2'b00) begin
            for (int d = 0; d < 4; d++) begin
               int er = r + 3*drs[d];
               int ec = c + 3*dcs[d];
               if (anchor < 0 && er < 6 && ec >= 0 && ec < 7) begin
                  logic same = 1'b1;
                  for (int i = 1; i < 4; i++)
                     if (cell_v(b, r + i*drs[d], c + i*dcs[d]) != a) same = 1'b0;
                  if (same) begin
                     anchor = k;
                     who    = a;
                  end
               end
            end
         end
      end
   endfunction

   // Drive a one-cycle request and push the expected outcome.
   task automatic start_scan(input logic [83:0] b, input string tag);
      exp_t e;
      int   anc;
      logic [1:0] w;
      logic f;
      ref_eval(b, anc, w, f);
      @(negedge clk);
      board     = b;
      check_win = 1'b1;
      e.tag   = tag;
      e.start = cyc_cnt + 1;
      e.lat   = (anc < 0) ? 43 : anc + 2;
      e.win   = (anc >= 0);
      e.who   = w;
      e.full  = f;
      sb.push_back(e);
      @(negedge clk);
      check_win = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check_val({tag, "_timeout"}, sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [83:0] b, input string tag);
      start_scan(b, tag);
      drain(tag);
   endtask

   // Done monitor: pop the oldest expectation and compare.
   always @(posedge clk) begin
      #1;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check_val("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_val({e.tag, "_lat"},  cyc_cnt - e.start, e.lat);
            check_val({e.tag, "_win"},  win_flag, e.win);
            check_val({e.tag, "_who"},  winner_id, e.who);
            check_val({e.tag, "_full"}, board_full, e.full);
            check_val({e.tag, "_busy"}, busy, 1);
            $display("scan %s: lat=%0d win=%0b who=%0d full=%0b",
                     e.tag, cyc_cnt - e.start, win_flag, winner_id, board_full);
         end
      end
   end

   initial begin
      logic [83:0] b;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_win",  win_flag, 0);
      check_val("rst_who",  winner_id, 0);
      check_val("rst_full", board_full, 0);

      run('0, "empty");

      b = '0;
      for (int c = 0; c < 4; c++) b = put(b, 0, c, 2'b01);
      run(b, "horiz_p1");
      repeat (3) @(negedge clk);
      check_val("hold_win",  win_flag, 1);
      check_val("hold_who",  winner_id, 2'b01);
      check_val("hold_busy", busy, 0);

      // Reset while idle clears latched results.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("rst_clr_win", win_flag, 0);
      check_val("rst_clr_who", winner_id, 0);

      b = '0;
      for (int r = 2; r < 6; r++) b = put(b, r, 6, 2'b10);
      run(b, "vert_p2");

      b = '0;
      for (int i = 0; i < 4; i++) b = put(b, i, 3 - i, 2'b01);
      run(b, "upleft_p1");

      b = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            b = put(b, r, c, ((((r / 2) + c) % 2) == 0) ? 2'b01 : 2'b10);
      run(b, "full_nowin");

      b = '0;
      for (int i = 0; i < 4; i++) b = put(b, 1 + i, 1 + i, 2'b10);
      for (int c = 0; c < 4; c++) b = put(b, 3, c, 2'b01);
      run(b, "two_players");

      b = '1;
      run(b, "all_code11");

      for (int t = 0; t < 4; t++) begin
         b = '0;
         for (int k = 0; k < 42; k++)
            if ($urandom_range(0, 2) == 0) b = put(b, k / 7, k % 7, 2'($urandom_range(1, 3)));
         run(b, $sformatf("rand%0d", t));
      end

      // Second request during a scan must be ignored.
      start_scan('0, "dbl_req");
      repeat (5) @(negedge clk);
      check_win = 1'b1;
      @(negedge clk);
      check_win = 1'b0;
      drain("dbl_req");
      repeat (50) @(negedge clk);

      // Board changes during a scan must not affect the result.
      start_scan('0, "board_chg");
      repeat (3) @(negedge clk);
      b = '0;
      for (int c = 0; c < 4; c++) b = put(b, 5, c, 2'b01);
      board = b;
      drain("board_chg");

      // Abort a scan with reset: no done pulse, outputs zero.
      b = '0;
      for (int r = 2; r < 6; r++) b = put(b, r, 6, 2'b10);
      @(negedge clk);
      board = b;
      check_win = 1'b1;
      @(negedge clk);
      check_win = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("abort_busy", busy, 0);
      check_val("abort_done", done, 0);
      check_val("abort_win",  win_flag, 0);
      check_val("abort_who",  winner_id, 0);
      check_val("abort_full", board_full, 0);
      repeat (60) @(negedge clk);

      run(b, "after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/connect4_win_checker.md
CONNECT4_WIN_CHECKER -- requirements
Module: connect4_win_checker

Interface
REQ-001 SHALL expose ports: clk  input  1  system clock, all logic on rising edge.
REQ-002 SHALL expose ports: rst  input  1  synchronous active-high reset.
REQ-003 SHALL expose ports: check_win  input  1  start-scan request from game controller, sampled each edge.
REQ-004 SHALL expose ports: board  input  84  board image; cell (r,c) at bits [2*(r*7+c)+1 : 2*(r*7+c)], r=0 bottom row; 00 empty, 01 P1, 10 P2, 11 treated as empty.
REQ-005 SHALL expose ports: busy  output  1  high while a scan is in progress.
REQ-006 SHALL expose ports: done  output  1  one-cycle pulse when the result is valid.
REQ-007 SHALL expose ports: win_flag  output  1  four-in-a-row found.
REQ-008 SHALL expose ports: winner_id  output  2  01 P1, 10 P2, 00 none.
REQ-009 SHALL expose ports: board_full  output  1  all 42 cells non-empty (valid at done).

Function
REQ-010 SHALL implement states IDLE, SCAN, DONE.
REQ-011 In IDLE, check_win=1 at an edge SHALL snapshot board, clear win_flag/winner_id/board_full accumulators, set cell index to 0, and enter SCAN.
REQ-012 Each SCAN cycle SHALL evaluate one anchor cell, index = r*7+c, order row 0..5, col 0..6 within a row.
REQ-013 Anchor evaluation SHALL test 4 lines of 4 identical non-empty cells: horizontal (c..c+3, requires c<=3), vertical (r..r+3, requires r<=2), up-right diagonal (r+i,c+i, requires r<=2,c<=3), up-left diagonal (r+i,c-i, requires r<=2,c>=3); out-of-range lines SHALL be ignored.
REQ-014 On the first anchor producing a line, SHALL latch win_flag=1 and winner_id=anchor value, and go to DONE (early termination).
REQ-015 With no win, SHALL go to DONE after evaluating index 41.
REQ-016 board_full SHALL be the AND of all cells non-empty on the snapshot; valid whenever done=1, including early termination.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency: check_win sampled at edge N; win at anchor k gives done=1 in the cycle after edge N+k+2; no win gives done=1 in the cycle after edge N+43.
REQ-019 busy SHALL be 1 in SCAN and DONE, 0 in IDLE.
REQ-020 check_win while busy=1 SHALL be ignored; changes to board during a scan SHALL not affect the result.
REQ-021 win_flag, winner_id and board_full SHALL hold their values after done until the next accepted check_win or rst.
REQ-022 If two players both have lines, the result SHALL be the first anchor in scan order.

Reset
REQ-023 rst=1 SHALL, at the next edge, force IDLE, index 0, busy=0, done=0, win_flag=0, winner_id=00, board_full=0, with priority over check_win, including mid-scan (no done pulse is produced for an aborted scan).

Structure
REQ-024 Shared package connect4_pkg SHALL hold ROWS=6, COLS=7, CELLS=42, cell_t (EMPTY=00, P1=01, P2=10), and the checker state enum.
REQ-025 Sub-module line4_eval (combinational: snapshot plus row/col in, hit plus player out) SHALL implement REQ-013.

Verification
REQ-026 Empty board, check_win pulse -> done exactly 43 cycles after sampling; win_flag=0, winner_id=00, board_full=0.
REQ-027 P1 at (0,0)-(0,3) -> done 2 cycles after sampling; win_flag=1, winner_id=01.
REQ-028 P2 at (2,6),(3,6),(4,6),(5,6), other cells empty -> anchor 20; done 22 cycles after sampling; winner_id=10.
REQ-029 P1 up-left diagonal (0,3),(1,2),(2,1),(3,0) -> anchor 3, done 5 cycles after sampling, winner_id=01; full no-win pattern -> done at 43 cycles, board_full=1, win_flag=0.
REQ-030 rst asserted at scan cycle 10 -> busy=0, no done pulse, outputs zero; a second check_win during SCAN -> ignored, single done pulse; board changed mid-scan -> result matches the snapshot.
